// File: rtl/morse_symbol_timer.sv
// -----------------------------------------------------------------------------
// morse_symbol_timer
//
// Upstream stage of the 4x2-bit symbol loader. Times key-down and key-up
// intervals of a Morse key against a tick timebase, classifies each press and
// emits one 2-bit symbol per sym_load pulse. Every letter is padded to exactly
// four symbols so the downstream loader always sees four loads per letter.
//
// Symbol codes: 2'b01 dot, 2'b10 dash, 2'b11 overlong press, 2'b00 pad.
//
// Ports:
//   clk        in   1  system clock, rising edge
//   rst        in   1  asynchronous reset, active-low
//   enable     in   1  block enable; low aborts the letter and holds in IDLE
//   key        in   1  debounced Morse key, asynchronous to clk, 1 = pressed
//   tick       in   1  one-cycle timebase strobe, one dot unit per tick
//   sym_out    out  2  symbol code, valid with sym_load, holds otherwise
//   sym_load   out  1  one-cycle strobe per emitted symbol
//   letter_end out  1  strobe coincident with the 4th sym_load of a letter
//   busy       out  1  high whenever the FSM is not in IDLE
// -----------------------------------------------------------------------------
module morse_symbol_timer #(
    parameter int unsigned DASH_TICKS       = 3,
    parameter int unsigned LETTER_GAP_TICKS = 3,
    parameter int unsigned MAX_PRESS_TICKS  = 15,
    parameter int unsigned CNT_W            = 5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic       key,
    input  logic       tick,
    output logic [1:0] sym_out,
    output logic       sym_load,
    output logic       letter_end,
    output logic       busy
);

    localparam logic [CNT_W-1:0] DASH_C = CNT_W'(DASH_TICKS);
    localparam logic [CNT_W-1:0] GAP_C  = CNT_W'(LETTER_GAP_TICKS);
    localparam logic [CNT_W-1:0] MAX_C  = CNT_W'(MAX_PRESS_TICKS);

    localparam logic [1:0] SYM_PAD  = 2'b00;
    localparam logic [1:0] SYM_DOT  = 2'b01;
    localparam logic [1:0] SYM_DASH = 2'b10;
    localparam logic [1:0] SYM_LONG = 2'b11;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRESS = 2'd1,
        GAP   = 2'd2,
        PAD   = 2'd3
    } state_t;

    state_t           state;
    logic             key_m;
    logic             key_s;
    logic             armed;
    logic [CNT_W-1:0] cnt;
    logic [1:0]       sym_cnt;

    logic [CNT_W-1:0] tick_ext;
    logic [CNT_W-1:0] press_next;
    logic [CNT_W-1:0] gap_next;
    logic [1:0]       press_code;

    // Two-flop synchronizer for the asynchronous key input.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            key_m <= 1'b0;
            key_s <= 1'b0;
        end else begin
            key_m <= key;
            key_s <= key_m;
        end
    end

    // Press count including a tick landing in the current cycle, so a release
    // that coincides with a tick still credits that tick.
    always_comb begin
        tick_ext   = {{(CNT_W-1){1'b0}}, tick};
        press_next = (cnt == MAX_C) ? MAX_C : cnt + tick_ext;
        gap_next   = cnt + tick_ext;
        if (press_next == MAX_C) begin
            press_code = SYM_LONG;
        end else if (press_next >= DASH_C) begin
            press_code = SYM_DASH;
        end else begin
            press_code = SYM_DOT;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            cnt        <= '0;
            sym_cnt    <= '0;
            armed      <= 1'b0;
            sym_out    <= '0;
            sym_load   <= 1'b0;
            letter_end <= 1'b0;
            busy       <= 1'b0;
        end else begin
            sym_load   <= 1'b0;
            letter_end <= 1'b0;

            if (!enable) begin
                // Discard any partial letter; sym_out keeps its last value.
                state   <= IDLE;
                cnt     <= '0;
                sym_cnt <= '0;
                armed   <= 1'b0;
                busy    <= 1'b0;
            end else begin
                // A key held through a disable must be released before it
                // can start a new press.
                if (!key_s) begin
                    armed <= 1'b1;
                end

                unique case (state)
                    IDLE: begin
                        if (key_s && armed) begin
                            state <= PRESS;
                            cnt   <= '0;
                            busy  <= 1'b1;
                        end
                    end

                    PRESS: begin
                        if (key_s) begin
                            cnt <= press_next;
                        end else if (press_next == '0) begin
                            // Release with no tick: glitch, no symbol.
                            cnt <= '0;
                            if (sym_cnt != 2'd0) begin
                                state <= GAP;
                                busy  <= 1'b1;
                            end else begin
                                state <= IDLE;
                                busy  <= 1'b0;
                            end
                        end else begin
                            sym_out  <= press_code;
                            sym_load <= 1'b1;
                            sym_cnt  <= sym_cnt + 2'd1;
                            cnt      <= '0;
                            if (sym_cnt == 2'd3) begin
                                letter_end <= 1'b1;
                                state      <= IDLE;
                                busy       <= 1'b0;
                            end else begin
                                state <= GAP;
                                busy  <= 1'b1;
                            end
                        end
                    end

                    GAP: begin
                        if (key_s) begin
                            state <= PRESS;
                            cnt   <= '0;
                        end else if (gap_next >= GAP_C) begin
                            state <= PAD;
                            cnt   <= '0;
                        end else begin
                            cnt <= gap_next;
                        end
                    end

                    PAD: begin
                        // Key is ignored here; at most three pad cycles.
                        sym_out  <= SYM_PAD;
                        sym_load <= 1'b1;
                        sym_cnt  <= sym_cnt + 2'd1;
                        if (sym_cnt == 2'd3) begin
                            letter_end <= 1'b1;
                            state      <= IDLE;
                            busy       <= 1'b0;
                        end
                    end

                    default: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_morse_symbol_timer.sv
// -----------------------------------------------------------------------------
// tb_morse_symbol_timer
//
// Directed bench for morse_symbol_timer. Emitted symbols are captured on the
// falling clock edge into queues and compared against hand-computed letters.
// -----------------------------------------------------------------------------
module tb_morse_symbol_timer;

    logic       clk;
    logic       rst;
    logic       enable;
    logic       key;
    logic       tick;
    logic [1:0] sym_out;
    logic       sym_load;
    logic       letter_end;
    logic       busy;

    int n_total = 0;
    int n_bad   = 0;
    int cyc     = 0;

    logic [1:0] q_sym[$];
    logic       q_le[$];
    int         q_cyc[$];

    morse_symbol_timer #(
        .DASH_TICKS      (3),
        .LETTER_GAP_TICKS(3),
        .MAX_PRESS_TICKS (15),
        .CNT_W           (5)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .enable    (enable),
        .key       (key),
        .tick      (tick),
        .sym_out   (sym_out),
        .sym_load  (sym_load),
        .letter_end(letter_end),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (sym_load) begin
            q_sym.push_back(sym_out);
            q_le.push_back(letter_end);
            q_cyc.push_back(cyc);
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic tick_pulse();
        tick = 1'b1;
        step(1);
        tick = 1'b0;
        step(3);
    endtask

    task automatic press(input int k);
        key = 1'b1;
        step(3);
        repeat (k) tick_pulse();
        key = 1'b0;
    endtask

    task automatic up(input int k);
        step(3);
        repeat (k) tick_pulse();
    endtask

    // codes: symbol 0 in [7:6] ... symbol 3 in [1:0]; le[i] for symbol i.
    task automatic check_letter(input string tag, input int n, input logic [7:0] codes,
                                input logic [3:0] le);
        check_eq({tag, ".count"}, q_sym.size(), n);
        for (int i = 0; i < n && i < q_sym.size(); i++) begin
            check_eq($sformatf("%s.sym%0d", tag, i), {30'd0, q_sym[i]}, {30'd0, codes[7-2*i -: 2]});
            check_eq($sformatf("%s.le%0d", tag, i), {31'd0, q_le[i]}, {31'd0, le[i]});
        end
        q_sym.delete();
        q_le.delete();
        q_cyc.delete();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: got=running expected=finished");
        $fatal(1, "timeout");
    end

    int rel;

    initial begin
        rst    = 1'b0;
        enable = 1'b1;
        key    = 1'b0;
        tick   = 1'b0;
        #12;
        check_eq("rst.sym_out", {30'd0, sym_out}, 32'd0);
        check_eq("rst.sym_load", {31'd0, sym_load}, 32'd0);
        check_eq("rst.letter_end", {31'd0, letter_end}, 32'd0);
        check_eq("rst.busy", {31'd0, busy}, 32'd0);
        rst = 1'b1;
        step(4);

        // 1: letter A, two pads on consecutive cycles
        press(1);
        rel = cyc;
        step(4);
        check_eq("a.lat", q_cyc.size() > 0 ? q_cyc[0] : -1, rel + 3);
        check_eq("a.busy_gap", {31'd0, busy}, 32'd1);
        up(0);
        step(0);
        up(1);
        press(4);
        up(3);
        step(3);
        check_eq("a.pad_adj", q_cyc.size() == 4 ? q_cyc[3] - q_cyc[2] : -1, 1);
        check_letter("a", 4, 8'b01_10_00_00, 4'b1000);
        check_eq("a.busy_end", {31'd0, busy}, 32'd0);

        // 2: four dashes, letter_end on 4th, no pads afterwards
        press(5); up(1);
        press(5); up(1);
        press(5); up(1);
        press(5); up(3);
        step(5);
        check_letter("dash4", 4, 8'b10_10_10_10, 4'b1000);
        check_eq("dash4.busy", {31'd0, busy}, 32'd0);

        // dot/dash/overlong thresholds
        press(2);  up(1);
        press(3);  up(1);
        press(14); up(1);
        press(15); up(3);
        step(5);
        check_letter("thr", 4, 8'b01_10_10_11, 4'b1000);

        // 3: tickless press from IDLE, then mid-letter
        key = 1'b1; step(5); key = 1'b0; step(5);
        check_eq("glitch.idle_cnt", q_sym.size(), 0);
        check_eq("glitch.idle_busy", {31'd0, busy}, 32'd0);
        press(1);
        step(4);
        key = 1'b1; step(5); key = 1'b0; step(5);
        check_eq("glitch.mid_busy", {31'd0, busy}, 32'd1);
        up(3);
        step(3);
        check_letter("glitch", 4, 8'b01_00_00_00, 4'b1000);
        check_eq("glitch.busy_end", {31'd0, busy}, 32'd0);

        // 4: 20-tick press saturates, single overlong symbol
        press(20);
        step(4);
        check_letter("long.first", 1, 8'b11_00_00_00, 4'b0000);
        up(3);
        step(3);
        check_letter("long.pads", 3, 8'b00_00_00_00, 4'b0100);

        // 5: reset during PAD after first pad
        press(1);
        step(3);
        repeat (3) begin
            tick = 1'b1; step(1); tick = 1'b0; step(1);
        end
        check_eq("rstpad.load", {31'd0, sym_load}, 32'd1);
        check_eq("rstpad.sym", {30'd0, sym_out}, 32'd0);
        rst = 1'b0;
        #1;
        check_eq("rstpad.load0", {31'd0, sym_load}, 32'd0);
        check_eq("rstpad.busy0", {31'd0, busy}, 32'd0);
        check_eq("rstpad.le0", {31'd0, letter_end}, 32'd0);
        #1;
        rst = 1'b1;
        q_sym.delete(); q_le.delete(); q_cyc.delete();
        up(4);
        step(4);
        check_letter("rstpad.after", 0, 8'h00, 4'b0000);

        // 6: enable drop mid-press with key held
        press(1);
        step(4);
        check_letter("en.first", 1, 8'b01_00_00_00, 4'b0000);
        key = 1'b1;
        step(3);
        tick_pulse();
        enable = 1'b0;
        step(3);
        check_eq("en.busy_off", {31'd0, busy}, 32'd0);
        check_eq("en.sym_hold", {30'd0, sym_out}, 32'd1);
        enable = 1'b1;
        step(3);
        tick_pulse();
        tick_pulse();
        check_eq("en.held_busy", {31'd0, busy}, 32'd0);
        key = 1'b0;
        step(6);
        check_eq("en.rel_cnt", q_sym.size(), 0);
        press(1);
        up(3);
        step(3);
        check_letter("en.fresh", 4, 8'b01_00_00_00, 4'b1000);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
